data_mem_access: RTL

- Multicycle RISC-V data-memory access sequencer.
- Sits between the datapath (effective address, rs2, instruction register) and a variable-latency 64-bit data memory.
- Produces the byte-lane-aligned doubleword Dataout, which the load-extension stage consumes before register write-back.
- Performs sub-doubleword stores (sb/sh/sw) by read-modify-write; sd is a single write.

---
 rtl/mem_access_pkg.sv | 33 +++
 rtl/store_merge.sv | 22 ++
 rtl/data_mem_access.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - opcodes, funct3 codes, FSM states and access-size helper
package mem_access_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    FIN   = 3'd4
  } state_e;

  // Byte count of an access; funct3 7 falls into the doubleword slot but is rejected upstream.
  function automatic logic [3:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = 4'd1;
      F3_H, F3_HU: size_of = 4'd2;
      F3_W, F3_WU: size_of = 4'd4;
      default:     size_of = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// rtl/store_merge.sv - replaces byte lanes [off .. off+size-1] of a doubleword with new low bytes
module store_merge (
  input  logic [63:0] old_word,
  input  logic [63:0] new_word,
  input  logic [2:0]  off,
  input  logic [3:0]  size,
  output logic [63:0] merged
);

  logic [7:0]  lane_en;
  logic [63:0] shifted;

  always_comb begin
    lane_en = 8'(((16'd1 << size) - 16'd1) << off);
    shifted = new_word << {off, 3'b000};
    merged  = old_word;
    for (int i = 0; i < 8; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = shifted[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_access.sv
// rtl/data_mem_access.sv - multicycle RISC-V load/store sequencer with read-modify-write sub-doubleword stores
module data_mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [63:0]       Dataout,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       sdata_q, sdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       dout_q, dout_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic        is_load, is_store, illegal, misalign, timeout;
  logic [3:0]  acc_size, merge_size;
  logic [2:0]  off;
  logic [63:0] merged;
  logic        unused_instr;

  assign unused_instr = ^{instr[31:15], instr[11:7]};
  assign off          = addr_q[2:0];
  assign merge_size   = size_of(f3_q);
  assign timeout      = (cnt_q == 8'(TIMEOUT - 1));

  store_merge u_store_merge (
    .old_word (rdata_q),
    .new_word (sdata_q),
    .off      (off),
    .size     (merge_size),
    .merged   (merged)
  );

  // Alignment is judged on the incoming request so a bad access never touches memory.
  always_comb begin
    is_load  = (instr[6:0] == OPC_LOAD);
    is_store = (instr[6:0] == OPC_STORE);
    acc_size = size_of(instr[14:12]);
    illegal  = is_load ? (instr[14:12] == 3'd7) : (instr[14:12] > F3_D);
    misalign = illegal || ((addr[2:0] & 3'(acc_size - 4'd1)) != 3'd0);
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    st_d    = st_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && (is_load || is_store)) begin
          f3_d    = instr[14:12];
          st_d    = is_store;
          addr_d  = addr;
          sdata_d = store_data;
          err_d   = misalign;
          cnt_d   = 8'd0;
          if (misalign)                        state_d = FIN;
          else if (is_store && instr[14:12] == F3_D) begin
            wdata_d = store_data;
            state_d = WR;
          end else                             state_d = RD;
        end
      end
      RD: begin
        if (mem_valid) begin
          if (st_q) begin
            rdata_d = mem_rdata;
            state_d = MERGE;
          end else begin
            dout_d  = mem_rdata >> {off, 3'b000};
            state_d = FIN;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else cnt_d = cnt_q + 8'd1;
      end
      MERGE: begin
        wdata_d = merged;
        cnt_d   = 8'd0;
        state_d = WR;
      end
      WR: begin
        if (mem_valid) state_d = FIN;
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else cnt_d = cnt_q + 8'd1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      f3_q    <= 3'd0;
      st_q    <= 1'b0;
      addr_q  <= '0;
      sdata_q <= 64'd0;
      rdata_q <= 64'd0;
      wdata_q <= 64'd0;
      dout_q  <= 64'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      st_q    <= st_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req   = (state_q == RD) || (state_q == WR);
  assign mem_we    = (state_q == WR);
  assign mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_wdata = wdata_q;
  assign Dataout   = dout_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign err       = (state_q == FIN) && err_q;

endmodule
